nrs_gold_gen: RTL and testbench

Length-31 Gold sequence generator for the NRS value generator. It sits directly downstream of the cinit stage (multiply/add producing c_init = 2^10·(7·(ns+1)+l+1)·(2·N_ID+1) + 2·N_ID + 1). It loads c_init and discards the first Nc bits plus the N_RB_max offset bits. It then streams the c(n) bit pairs that the QPSK mapper consumes to form r(m).

---
 rtl/nrs_pkg.sv | 26 ++
 rtl/lfsr31_adv.sv | 24 ++
 rtl/nrs_gold_gen.sv | 140 ++++++++++++++
 tb/tb_nrs_gold_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// Shared constants, tap masks and FSM state type for the NRS sequence chain
// (cinit stage and Gold generator).
package nrs_pkg;

  localparam int CINIT_W     = 31;
  localparam int NC_DEFAULT  = 1600;
  localparam int N_RB_MAX_DL = 110;

  // Feedback taps: bit k of the mask selects x(n+k) in the recursion for x(n+31).
  localparam logic [CINIT_W-1:0] X1_TAPS = 31'h0000_0009;
  localparam logic [CINIT_W-1:0] X2_TAPS = 31'h0000_000F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARM,
    ST_SKIP,
    ST_OUT
  } gold_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lfsr31_adv.sv
// Combinational advance of the x1/x2 Gold register pair by STEPS positions.
module lfsr31_adv
  import nrs_pkg::*;
#(
  parameter int STEPS = 2
) (
  input  logic [CINIT_W-1:0] x1,
  input  logic [CINIT_W-1:0] x2,
  output logic [CINIT_W-1:0] x1_next,
  output logic [CINIT_W-1:0] x2_next
);

  // NOTE: blocking assignments here model a chain of single steps that must
  // see each previous step's result within the same evaluation.
  always_comb begin
    x1_next = x1;
    x2_next = x2;
    for (int s = 0; s < STEPS; s++) begin
      x1_next = {^(x1_next & X1_TAPS), x1_next[CINIT_W-1:1]};
      x2_next = {^(x2_next & X2_TAPS), x2_next[CINIT_W-1:1]};
    end
  end

endmodule

// File: rtl/nrs_gold_gen.sv
// Length-31 Gold sequence generator: warm-up, offset skip, then c(n) pairs.
// Optional build macro GOLD_FASTSKIP_EN: 4 steps per clock during warm-up.
module nrs_gold_gen
  import nrs_pkg::*;
#(
  parameter int NC         = NC_DEFAULT,
  parameter int SKIP_PAIRS = N_RB_MAX_DL - 1,
  parameter int PAIRS      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CINIT_W-1:0] cinit,
  input  logic               c_ready,
  output logic [1:0]         c_pair,
  output logic               c_valid,
  output logic               busy,
  output logic               done
);

`ifdef GOLD_FASTSKIP_EN
  localparam int WARM_CYC = NC / 4;
`else
  localparam int WARM_CYC = NC / 2;
`endif
  localparam int CNT_W = $clog2(max3(WARM_CYC, SKIP_PAIRS, PAIRS)) + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t WARM_LAST = cnt_t'(WARM_CYC - 1);
  localparam cnt_t SKIP_LAST = cnt_t'(SKIP_PAIRS - 1);
  localparam cnt_t PAIR_LAST = cnt_t'(PAIRS - 1);

  gold_state_t        state_q, state_d;
  logic [CINIT_W-1:0] x1_q, x2_q, x1_d, x2_d;
  logic [CINIT_W-1:0] x1_s2, x2_s2, x1_warm, x2_warm;
  cnt_t               cnt_q, cnt_d;
  logic [1:0]         c_pair_d;
  logic               c_valid_d, done_d;

  lfsr31_adv #(.STEPS(2)) u_adv2 (
    .x1(x1_q), .x2(x2_q), .x1_next(x1_s2), .x2_next(x2_s2)
  );

`ifdef GOLD_FASTSKIP_EN
  lfsr31_adv #(.STEPS(4)) u_adv4 (
    .x1(x1_q), .x2(x2_q), .x1_next(x1_warm), .x2_next(x2_warm)
  );
`else
  assign x1_warm = x1_s2;
  assign x2_warm = x2_s2;
`endif

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    cnt_d     = cnt_q;
    c_pair_d  = c_pair;
    c_valid_d = c_valid;
    done_d    = 1'b0;
    // A load strobe overrides everything, including a coincident final handshake.
    if (start) begin
      state_d   = ST_WARM;
      x1_d      = 31'd1;
      x2_d      = cinit;
      cnt_d     = '0;
      c_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WARM: begin
          x1_d = x1_warm;
          x2_d = x2_warm;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = (SKIP_PAIRS == 0) ? ST_OUT : ST_SKIP;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        ST_SKIP: begin
          x1_d = x1_s2;
          x2_d = x2_s2;
          if (cnt_q == SKIP_LAST) begin
            cnt_d   = '0;
            state_d = ST_OUT;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        ST_OUT: begin
          // First OUT cycle registers the pair; later pairs load from the
          // post-handshake register contents so throughput is one per clock.
          if (!c_valid) begin
            c_pair_d  = {x1_q[1] ^ x2_q[1], x1_q[0] ^ x2_q[0]};
            c_valid_d = 1'b1;
          end else if (c_ready) begin
            x1_d = x1_s2;
            x2_d = x2_s2;
            if (cnt_q == PAIR_LAST) begin
              cnt_d     = '0;
              c_valid_d = 1'b0;
              done_d    = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              cnt_d    = cnt_q + cnt_t'(1);
              c_pair_d = {x1_s2[1] ^ x2_s2[1], x1_s2[0] ^ x2_s2[0]};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x1_q    <= 31'd1;
      x2_q    <= '0;
      cnt_q   <= '0;
      c_pair  <= '0;
      c_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      cnt_q   <= cnt_d;
      c_pair  <= c_pair_d;
      c_valid <= c_valid_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_nrs_gold_gen.sv
// Self-checking bench for nrs_gold_gen against a bit-serial Gold sequence model.
module tb_nrs_gold_gen;

  localparam int NC         = 1600;
  localparam int SKIP_PAIRS = 109;
  localparam int PAIRS      = 2;
  localparam int FIRST_BIT  = NC + 2 * SKIP_PAIRS;
  localparam int MLEN       = FIRST_BIT + 2 * PAIRS;
`ifdef GOLD_FASTSKIP_EN
  localparam int LAT = NC / 4 + SKIP_PAIRS + 1;
`else
  localparam int LAT = NC / 2 + SKIP_PAIRS + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [30:0] cinit = '0;
  logic        c_ready = 1'b0;
  logic [1:0]  c_pair;
  logic        c_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_pairs [PAIRS];

  nrs_gold_gen #(.NC(NC), .SKIP_PAIRS(SKIP_PAIRS), .PAIRS(PAIRS)) dut (
    .clk(clk), .rst(rst), .start(start), .cinit(cinit), .c_ready(c_ready),
    .c_pair(c_pair), .c_valid(c_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bit-serial reference: unroll both recursions over plain bit arrays.
  task automatic model_fill(input logic [30:0] ci);
    bit x1 [MLEN + 31];
    bit x2 [MLEN + 31];
    int b;
    for (int k = 0; k < 31; k++) begin
      x1[k] = (k == 0);
      x2[k] = ci[k];
    end
    for (int n = 0; n < MLEN; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int i = 0; i < PAIRS; i++) begin
      b = FIRST_BIT + 2 * i;
      exp_pairs[i] = {x1[b+1] ^ x2[b+1], x1[b] ^ x2[b]};
    end
  endtask

  // Full run from a start at the current negedge; mode 0 ready high,
  // 1 random ready, 2 ready low for the first 5 valid cycles.
  task automatic run_one(input logic [30:0] ci, input int mode, input string tag);
    int  k, idx, stall, guard;
    logic r;
    model_fill(ci);
    cinit = ci;
    start = 1'b1;
    c_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cinit = 31'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL %s busy_rise: got %b want 1", tag, busy);
    end
    k = 0;
    while (c_valid !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
      if (done !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL %s early_done at cycle %0d", tag, k);
      end
    end
    n_cmp++;
    if (k !== LAT) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, k, LAT);
    end
    idx = 0; stall = 0; guard = 0;
    while (idx < PAIRS && guard < 200) begin
      guard++;
      n_cmp++;
      if (c_valid !== 1'b1 || done !== 1'b0) begin
        n_bad++; $display("FAIL %s valid_hold[%0d]: valid=%b done=%b want 1/0", tag, idx, c_valid, done);
      end
      n_cmp++;
      if (c_pair !== exp_pairs[idx]) begin
        n_bad++; $display("FAIL %s pair[%0d]: got %b want %b", tag, idx, c_pair, exp_pairs[idx]);
      end
      case (mode)
        1:       r = 1'($urandom_range(0, 1));
        2:       r = (stall >= 5);
        default: r = 1'b1;
      endcase
      if (!r) stall++;
      c_ready = r;
      @(negedge clk);
      if (r) idx++;
    end
    n_cmp++;
    if (idx !== PAIRS) begin
      n_bad++; $display("FAIL %s out_timeout: accepted %0d want %0d", tag, idx, PAIRS);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || c_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s done_cycle: done=%b busy=%b valid=%b want 1/0/0", tag, done, busy, c_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL %s done_width: got %b want 0", tag, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({c_pair, c_valid, busy, done} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 00000", {c_pair, c_valid, busy, done});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || c_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: busy=%b valid=%b want 0/0", busy, c_valid);
    end
  endtask

  task automatic test_basic();
    run_one(31'h3401, 0, "basic");
  endtask

  task automatic test_zero_cinit();
    run_one(31'h0, 0, "zero");
  endtask

  task automatic test_backpressure();
    run_one(31'h1234_567, 2, "bp5");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) run_one(31'($urandom), 1, "rand");
  endtask

  task automatic test_restart();
    cinit = 31'($urandom);
    start = 1'b1;
    c_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      if (done !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL restart first_run_done at %0d", i);
      end
    end
    run_one(31'h7FFF_FFFF, 0, "restart");
  endtask

  task automatic test_rst_mid();
    int k;
    cinit = 31'h3401;
    start = 1'b1;
    c_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (c_valid !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (c_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid reach_out: valid=%b want 1", c_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({c_pair, c_valid, busy, done} !== 5'b0) begin
      n_bad++; $display("FAIL rst_mid async_clear: got %b want 00000", {c_pair, c_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    c_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || c_valid !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid stay_idle[%0d]: busy=%b valid=%b want 0/0", i, busy, c_valid);
      end
    end
    run_one(31'h3401, 0, "post_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cinit();
    test_backpressure();
    test_random();
    test_restart();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
